// File: rtl/word_addr_reader.sv
// Byte-to-word read unit: checks word alignment, issues a word-indexed memory
// read with a bounded wait for the acknowledge, and returns data or an error code.
module word_addr_reader #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Ready is decoded straight from the state so a request is seen the same cycle.
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= ERR_MISALIGN;
            end else begin
              state    <= BUSY;
              mem_en   <= 1'b1;
              mem_addr <= req_addr[ADDR_W-1:2];
              cnt      <= '0;
            end
          end
        end
        BUSY: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= mem_rdata;
            rsp_err   <= ERR_OK;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_addr_reader.sv
// Randomized bench for word_addr_reader; each read is predicted at transaction
// level (mem_en length, error code, data, word index) and compared cycle by cycle.
module tb_word_addr_reader;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              mem_en;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  word_addr_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete read. ack_at = k acks on the k-th mem_en cycle; 0 or > TIMEOUT means never.
  task automatic run_txn(input logic [31:0] addr, input int ack_at,
                         input logic [31:0] data, input int hold);
    logic        misal;
    logic [1:0]  exp_err;
    logic [31:0] exp_data;
    int          exp_en;
    int          en_cnt;
    int          cycles;
    misal    = (addr[1:0] != 2'b00);
    exp_err  = misal ? 2'b01 : ((ack_at >= 1 && ack_at <= TIMEOUT) ? 2'b00 : 2'b10);
    exp_data = (exp_err == 2'b00) ? data : 32'h0;
    exp_en   = misal ? 0 : ((exp_err == 2'b00) ? ack_at : TIMEOUT);

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;

    en_cnt = 0;
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      if (mem_en) begin
        en_cnt++;
        chk("mem_addr", mem_addr, {2'b00, addr[31:2]});
        mem_ack   = (en_cnt == ack_at);
        mem_rdata = mem_ack ? data : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      step();
      cycles++;
    end
    mem_ack = 1'b0;
    chk("rsp_timeout_bound", rsp_valid, 1);
    chk("mem_en_cycles", en_cnt, exp_en);
    chk("rsp_latency", cycles, exp_en);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_data);
    chk("mem_en_after", mem_en, 0);

    // Backpressure: response held, new requests refused, stray acks ignored.
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'($urandom % 2);
      req_addr  = $urandom & 32'hFFFF_FFFC;
      mem_ack   = 1'($urandom % 2);
      mem_rdata = $urandom;
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_ready", req_ready, 0);
      chk("hold_mem_en", mem_en, 0);
    end

    // Handshake edge with a request pending: it must not be taken on this edge.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = $urandom & 32'hFFFF_FFFC;
    mem_ack   = 1'b0;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
    chk("post_hs_mem_en", mem_en, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_release_ready", req_ready, 1);
  endtask

  task automatic test_aligned();
    run_txn(32'h0000_0010, 3, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_misaligned();
    run_txn(32'h0000_0013, 0, 32'h0, 1);
  endtask

  task automatic test_timeout();
    run_txn(32'h0000_0100, 0, 32'h0, 4);
  endtask

  task automatic test_ack_boundary();
    run_txn(32'h0000_0200, TIMEOUT, 32'h1234_5678, 0);
  endtask

  task automatic test_backpressure();
    run_txn(32'h0000_0040, 2, 32'hA5A5_5A5A, 5);
    run_txn(32'hFFFF_FFFC, 1, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if (($urandom % 4) != 0) a[1:0] = 2'b00;
      run_txn(a, int'($urandom_range(0, TIMEOUT + 2)), $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0800;
    step();
    req_valid = 1'b0;
    chk("mid_busy_en", mem_en, 1);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_mem_en", mem_en, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_rsp_err", rsp_err, 0);
    chk("async_req_ready", req_ready, 1);
    step();
    step();
    #3;
    rst_n = 1'b1;
    step();
    chk("after_rst_ready", req_ready, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_valid", rsp_valid, 0);
      chk("late_ack_mem_en", mem_en, 0);
      chk("late_ack_ready", req_ready, 1);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_timeout();
    test_ack_boundary();
    test_backpressure();
    test_random();
    test_reset_mid_busy();
    run_txn(32'h0000_0020, 1, 32'h0BAD_CAFE, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/word_addr_reader.md
Name: word_addr_reader

Overview:
- Memory-side read unit that takes a byte address from the core and converts it to a word index (address right-shifted by 2) for a word-addressed memory.
- Checks alignment, runs the memory request/acknowledge handshake with a timeout, and returns the read data or an error code over a valid/ready response channel.
- Sits between the address path and the instruction/data word memory.
- Performs the inverse of the word-to-byte left shift used elsewhere in the datapath.

Parameters:
- ADDR_W, 32, byte address width; mem_addr is ADDR_W-2 bits.
- DATA_W, 32, memory word width.
- TIMEOUT, 8, maximum number of cycles mem_en stays high waiting for mem_ack; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- mem_en  out  1  memory read request.
- mem_addr  out  ADDR_W-2  word index, equal to req_addr[ADDR_W-1:2].
- mem_ack  in  1  memory data valid, one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  read data; 0 on error.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout; 11 is never driven.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low.
- Reset values: all outputs 0 except req_ready. req_ready=1 once state=IDLE. State IDLE, counter 0.
- Register outputs: all outputs are registered except req_ready, which is decoded directly from the state register (1 only in IDLE).
- States: IDLE, BUSY, RESP.
- IDLE:
  - Accept when req_valid&req_ready at edge N.
  - If req_addr[1:0]!=0: go to RESP at N+1 with rsp_err=01, rsp_data=0. mem_en is never asserted.
  - Else: go to BUSY. mem_en=1 and mem_addr=req_addr[ADDR_W-1:2] from N+1; counter cleared.
- BUSY:
  - mem_en and mem_addr are held stable; counter increments each cycle.
  - mem_ack sampled high: capture mem_rdata into rsp_data, rsp_err=00, mem_en=0 next cycle, go to RESP.
  - No ack on the TIMEOUT-th mem_en cycle (counter==TIMEOUT-1): mem_en=0, rsp_data=0, rsp_err=10, go to RESP.
  - mem_en is therefore high for at most TIMEOUT cycles.
  - mem_ack on the final cycle, coinciding with timeout: ack wins, result is ok.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid=0 next cycle, return to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake; there is no overlap and no bypass.
- Latency, aligned read: request accept → mem_en is 1 cycle. mem_ack edge → rsp_valid is 1 cycle.
- Latency, misaligned read: request accept → rsp_valid is 1 cycle.
- Stray acks: mem_ack outside BUSY is ignored, including a late ack after a timeout.
- Address width rule: upper address bits pass straight through with no carry or wrap logic. 0xFFFF_FFFC maps to 0x3FFF_FFFF.
- Reset mid-operation: all outputs immediately return to reset values; any in-flight memory access is abandoned, and an ack arriving after reset is ignored.
- Input sampling: req_addr is sampled only on the accept edge; later changes have no effect.

Test Plan:
- Aligned read: req_addr=0x0000_0010, mem_ack 3 cycles after mem_en with mem_rdata=0xDEADBEEF → mem_addr=0x4, mem_en high 3 cycles, rsp_data=0xDEADBEEF, rsp_err=00, rsp_valid 1 cycle after ack.
- Misaligned read: req_addr=0x0000_0013 → mem_en stays 0 throughout, rsp_valid the next cycle, rsp_err=01, rsp_data=0.
- Timeout: TIMEOUT=8, no mem_ack → mem_en high exactly 8 cycles, rsp_err=10. An ack injected 2 cycles later does not change the response or the state.
- Ack on the boundary: mem_ack on the 8th mem_en cycle with 0x1234_5678 → rsp_err=00, rsp_data=0x1234_5678.
- Backpressure and edge address: rsp_ready held low for 5 cycles → rsp_valid, rsp_data and rsp_err stable, req_ready=0, a concurrent req_valid is not accepted. Then req_addr=0xFFFF_FFFC → mem_addr=0x3FFF_FFFF.
- Reset mid-BUSY: rst_n low 2 cycles after mem_en rises → mem_en, rsp_valid and rsp_err are 0 asynchronously. After release, req_ready=1 and an ack arriving then produces no response.
